// File: rtl/cvez_arbiter.sv
// cvez_arbiter: round-robin scheduler for the shared up/down counter Cvez.
// Each requester may queue one inc/dec request. Ops go to the counter one
// at a time as registered Sm/Rs strobes. A shadow copy tracks the count.
// Optional build macro CVEZ_ARB_SAT_EN: saturate at MAX_VAL/MIN_VAL
// instead of wrapping, and report suppressed ops on sat.
module cvez_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned MAX_VAL  = 3,
    parameter int unsigned MIN_VAL  = 0,
    parameter int unsigned COOLDOWN = 2
) (
    input  logic             CLK,
    input  logic             Rst,
    input  logic [N_REQ-1:0] req_inc,
    input  logic [N_REQ-1:0] req_dec,
    output logic             Sm,
    output logic             Rs,
    output logic [N_REQ-1:0] grant,
    output logic             sat,
    output logic             drop,
    output logic [WIDTH-1:0] shadow,
    output logic             busy
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
`ifdef CVEZ_ARB_SAT_EN
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] MINV = WIDTH'(MIN_VAL);
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, COOL} state_t;

    state_t           state;
    logic [N_REQ-1:0] pend_v;
    logic [N_REQ-1:0] pend_d;
    logic [N_REQ-1:0] pend_v_nxt;
    logic [N_REQ-1:0] pend_d_nxt;
    logic             drop_nxt;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    idx;
    logic [PW-1:0]    pick;
    logic             hit;
    logic             consume;
    logic             suppress;
    logic [3:0]       cool_cnt;

    assign consume = (state == IDLE) && hit;
    assign busy    = (|pend_v) || (state != IDLE);

    // Round-robin search of pending requests, starting at the pointer.
    always_comb begin
        idx  = '0;
        hit  = 1'b0;
        pick = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            idx = PW'((32'(ptr) + j) % N_REQ);
            if (!hit && pend_v[idx]) begin
                hit  = 1'b1;
                pick = idx;
            end
        end
    end

    // Decide whether the selected op would push the count past a limit.
    always_comb begin
        suppress = 1'b0;
`ifdef CVEZ_ARB_SAT_EN
        if (hit) begin
            suppress = pend_d[pick] ? (shadow == MAXV) : (shadow == MINV);
        end
`endif
    end

    // Next pending flags: grant clears first, so a same-cycle request re-latches.
    always_comb begin
        pend_v_nxt = pend_v;
        pend_d_nxt = pend_d;
        drop_nxt   = 1'b0;
        if (consume) begin
            pend_v_nxt[pick] = 1'b0;
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_inc[i] && req_dec[i]) begin
                drop_nxt = 1'b1;
            end else if (req_inc[i] || req_dec[i]) begin
                if (pend_v[i] && !(consume && (32'(pick) == i))) begin
                    drop_nxt = 1'b1;
                end else begin
                    pend_v_nxt[i] = 1'b1;
                    pend_d_nxt[i] = req_inc[i];
                end
            end
        end
    end

    // Pending request latch and drop pulse.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            pend_v <= '0;
            pend_d <= '0;
            drop   <= 1'b0;
        end else begin
            pend_v <= pend_v_nxt;
            pend_d <= pend_d_nxt;
            drop   <= drop_nxt;
        end
    end

    // Arbitration FSM with registered strobes and shadow count.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cool_cnt <= '0;
            Sm       <= 1'b0;
            Rs       <= 1'b0;
            grant    <= '0;
            sat      <= 1'b0;
            shadow   <= '0;
        end else begin
            Sm    <= 1'b0;
            Rs    <= 1'b0;
            grant <= '0;
            sat   <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit) begin
                        grant <= N_REQ'(1) << pick;
                        sat   <= suppress;
                        Sm    <= !suppress && pend_d[pick];
                        Rs    <= !suppress && !pend_d[pick];
                        ptr   <= PW'((32'(pick) + 32'd1) % N_REQ);
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (Sm) begin
                        shadow <= shadow + WIDTH'(1);
                    end else if (Rs) begin
                        shadow <= shadow - WIDTH'(1);
                    end
                    if (COOLDOWN > 0) begin
                        cool_cnt <= 4'(COOLDOWN);
                        state    <= COOL;
                    end else begin
                        state <= IDLE;
                    end
                end
                COOL: begin
                    if (cool_cnt <= 4'd1) begin
                        state <= IDLE;
                    end else begin
                        cool_cnt <= cool_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cvez_arbiter.md
# cvez_arbiter

Round-robin scheduler that shares the 2-bit up/down counter `Cvez` between several game-logic requesters. Examples of requesters are mouse-click handling, alien-hit detection and the player-hit event. Each requester raises single-cycle increment or decrement requests. The block queues at most one request per requester, issues one `Sm`/`Rs` pulse at a time to the counter, and keeps a shadow copy of the count so it can saturate instead of wrapping.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..8).
- `WIDTH`, default 2: counter width; must match the driven counter.
- `MAX_VAL`, default 3: upper saturation limit.
- `MIN_VAL`, default 0: lower saturation limit.
- `COOLDOWN`, default 2: idle cycles after each issue before the next arbitration (0..15).

Ports:
- `CLK`, in, 1: clock; all logic is on the rising edge.
- `Rst`, in, 1: synchronous, active-high reset. Shared with the counter.
- `req_inc`, in, N_REQ: per-requester increment request, one-cycle pulse.
- `req_dec`, in, N_REQ: per-requester decrement request, one-cycle pulse.
- `Sm`, out, 1: increment strobe to the counter, registered.
- `Rs`, out, 1: decrement strobe to the counter, registered.
- `grant`, out, N_REQ: one-hot; identifies the requester served in the ISSUE cycle.
- `sat`, out, 1: one-cycle pulse when the granted op was suppressed by a limit.
- `drop`, out, 1: one-cycle pulse when an incoming request was discarded.
- `shadow`, out, WIDTH: mirror of the counter value.
- `busy`, out, 1: high when any request is pending or the FSM is not IDLE.

## Operation
- Reset values:
  - All outputs are 0.
  - Pending flags are cleared.
  - Round-robin pointer is 0.
  - FSM is in IDLE.
  - `shadow` is 0, which matches the counter's reset value of 0.
- Pending latch (every cycle, all states):
  - Per requester `i`: `pend_v[i]` is a valid flag and `pend_d[i]` is the direction (1 = inc).
  - `req_inc[i]` and `req_dec[i]` both high in the same cycle: they cancel. Nothing is latched and `drop` pulses.
  - A new request while `pend_v[i]` is set and not being granted this cycle: the request is ignored and `drop` pulses.
  - A new request in the same cycle that `pend_v[i]` is consumed: the new request is latched, so nothing is lost.
- FSM states: IDLE, ISSUE, COOL.
- IDLE:
  - Search `pend_v` from the pointer upward, wrapping modulo N_REQ.
  - On a hit at index `k`:
    - Register `grant = 1<<k`.
    - Register `Sm = pend_d[k]` and `Rs = !pend_d[k]`.
    - Clear `pend_v[k]`.
    - Set the pointer to `(k+1) mod N_REQ`.
    - Go to ISSUE.
  - With no pending request, stay in IDLE.
- Limit check in IDLE (limit mode only):
  - An inc with `shadow == MAX_VAL`, or a dec with `shadow == MIN_VAL`, is suppressed.
  - For a suppressed op: `grant` and `sat` are registered and `Sm`/`Rs` stay 0.
  - The pointer and pending flag update as normal.
- ISSUE (exactly one cycle):
  - `Sm` or `Rs` is high, or `sat` is high.
  - `shadow` updates by ±1 at the end of this cycle, on the same edge as the counter.
  - Next state is COOL if `COOLDOWN > 0`, else IDLE.
- COOL:
  - A down-counter is loaded with COOLDOWN and decremented each cycle.
  - Return to IDLE when it reaches 1.
  - `Sm`, `Rs`, `grant` and `sat` are 0.
- `Sm` and `Rs` are never high together. They are never high outside ISSUE.
- `shadow` arithmetic is modulo 2^WIDTH.
- `Rst` mid-operation: return to the reset state on the next edge. The counter clears on the same edge, so `shadow` stays coherent.

## Timing
- Request pulse in cycle t → pending flag set at edge t.
- Arbitration happens in cycle t+1; `Sm`/`Rs`/`grant` are high in cycle t+2.
- The counter and `shadow` hold the new value from cycle t+3 onward.
- Best-case issue-to-issue spacing is 2 + COOLDOWN cycles.
- Worst-case wait for a requester is N_REQ·(2 + COOLDOWN) cycles after its request is latched.
- `drop` pulses one cycle after the offending request. `sat` pulses in the ISSUE slot.

## Configuration
- `CVEZ_ARB_SAT_EN` defined:
  - Limit checks against MAX_VAL and MIN_VAL are active.
  - `sat` functions as described above.
- `CVEZ_ARB_SAT_EN` undefined:
  - No limit check; every granted op drives `Sm` or `Rs`.
  - The counter and `shadow` wrap (3+1 → 0, 0−1 → 3).
  - `sat` is tied to 0.

## Test plan
- Reset, then `req_inc[0]` pulse at cycle 1:
  - `grant = 0001` and `Sm = 1` in cycle 3; `shadow = 1` in cycle 4.
  - `busy` is 0 from cycle 4 + COOLDOWN.
- `req_inc` = 4'b1111 in one cycle, COOLDOWN = 2:
  - Grants come in order 0, 1, 2, 3, spaced 4 cycles apart.
  - `shadow` ends at 3 (SAT_EN: the 4th op gives `sat = 1` and no `Sm`).
  - Without SAT_EN, `shadow` wraps to 0.
- `shadow = 0` and `req_dec[2]`:
  - SAT_EN: `grant = 0100`, `sat = 1`, `Rs = 0`, `shadow` stays 0.
  - No SAT_EN: `Rs = 1` and `shadow = 3`.
- `req_inc[1]` and `req_dec[1]` in the same cycle: `drop = 1` next cycle and no grant ever follows.
- Second `req_inc[1]` while the first is still pending (other requesters busy): `drop = 1` and only one `Sm` is issued for requester 1.
- `Rst` asserted during ISSUE: the next cycle has all outputs 0, `shadow = 0`, and the pending queue empty.
